ahb_slave_mem: RTL
==================

# ahb_slave_mem

AHB-Lite responder: word-organised SRAM slave that answers the transfers driven onto the `ahb_interface` signal set by the bench's master agent. It sits at the slave end of the bus as the DUT for the AHB UVM environment. It supports:
- byte, halfword and word accesses;
- a configurable number of wait states;
- a two-cycle ERROR response for illegal accesses.

## Interface
- `MEM_DEPTH`, 256: number of 32-bit words; the legal byte range is `0 .. MEM_DEPTH*4-1`.
- `WAIT_STATES`, 0: cycles with `HREADYout` held low before the completing cycle of each OKAY data phase (0–15).
- `HCLK` input 1: bus clock; everything is on the rising edge.
- `HRESET_n` input 1: reset, asynchronous and active-low.
- `HTRANS` input 2: `00` IDLE, `01` BUSY, `10` NONSEQ, `11` SEQ.
- `HBURST` input 3: burst type; informational only, the master supplies every beat address.
- `HSIZE` input 3: `000` byte, `001` halfword, `010` word; other codes are illegal.
- `HADDR` input 32: byte address.
- `HWRITE` input 1: 1 means write.
- `HWDATA` input 32: write data, valid in the data phase.
- `HRDATA` output 32: read data.
- `HREADYin` input 1: bus ready; the single-slave system ties it to `HREADYout`.
- `HREADYout` output 1: slave ready or transfer complete.
- `HRESP` output 2: `00` OKAY, `01` ERROR. RETRY and SPLIT are never generated.

## Operation
- **Slave selection:** the slave is always selected; there is no decoder.
- **Address-phase sampling:** the address phase is accepted on an edge where `HREADYin`=1.
- **Active transfer (NONSEQ/SEQ):** the slave registers `HADDR`, `HSIZE` and `HWRITE`, then enters its data phase.
- **IDLE/BUSY:** the next data phase is zero-wait OKAY with no memory effect.
- **Legality check** (only with `AHB_SLV_ERR_EN`), at address-phase acceptance; a transfer is illegal if:
  - `HADDR` ≥ `MEM_DEPTH*4`, or
  - `HSIZE` > `010`, or
  - it is misaligned: halfword with `HADDR[0]`=1, or word with `HADDR[1:0]`≠0.
- **FSM states:**
  - `IDLE`: no data phase pending; `HREADYout`=1, `HRESP`=OKAY.
  - `WAIT`: counts `WAIT_STATES` cycles; `HREADYout`=0, `HRESP`=OKAY.
  - `DATA`: completing cycle; `HREADYout`=1, `HRESP`=OKAY.
  - `ERR1`: `HREADYout`=0, `HRESP`=ERROR.
  - `ERR2`: `HREADYout`=1, `HRESP`=ERROR.
- **FSM transitions:**
  - An accepted legal transfer goes to `WAIT` if `WAIT_STATES`>0, else to `DATA`.
  - An accepted illegal transfer goes to `ERR1`; `ERR1` always goes to `ERR2`. Errors never take wait states.
  - From `DATA`, `ERR2` or `IDLE`, a new address phase is accepted in the same cycle, so back-to-back pipelining is supported.
  - No accepted active transfer (including a master cancelling with IDLE during `ERR2`) goes to `IDLE`.
- **Writes:**
  - `HWDATA` is sampled on the `DATA` cycle edge.
  - Byte lanes are little-endian, selected by the registered `HSIZE` and `HADDR[1:0]`; unselected bytes are unchanged.
  - Word index is `HADDR[log2(MEM_DEPTH)+1:2]`.
- **Reads:**
  - In `DATA`, `HRDATA` = the full 32-bit word at the registered address. All lanes are driven; the master extracts its lane.
  - Outside a read `DATA` cycle, `HRDATA` = 0.
- **Write-then-read:** a read whose address phase coincides with a write's `DATA` cycle returns the newly written data.
- **Reset:** the memory array is not reset. `HREADYout`=1, `HRESP`=`00`, `HRDATA`=0, FSM=`IDLE`, wait counter=0. An assertion mid-transfer discards the pending write.

## Timing
- Zero-wait transfer: address phase at cycle N; `DATA` at N+1 with `HREADYout`=1. `HRDATA` is valid at N+1, or `HWDATA` is captured at the end of N+1.
- With `WAIT_STATES`=W, `HREADYout` is low for cycles N+1 .. N+W and high at N+W+1.
- ERROR: `HRESP`=`01` at N+1 and N+2; `HREADYout` is 0 at N+1 and 1 at N+2.
- `HRDATA` is combinational from the registered address into the array. `HREADYout` and `HRESP` are registered.

## Configuration
- **`AHB_SLV_ERR_EN` defined:** the legality checks above apply and generate the two-cycle ERROR response.
- **`AHB_SLV_ERR_EN` undefined:**
  - `HRESP` is constant OKAY, and the `ERR1`/`ERR2` states are removed.
  - Addresses wrap modulo `MEM_DEPTH*4`.
  - Misaligned addresses are aligned down to the access size.
  - `HSIZE` > `010` is treated as a word access.

## Structure
- **Package `ahb_slv_pkg`:**
  - `htrans_e`, `hsize_e` and `hresp_e` encodings;
  - `slv_state_e` (`IDLE`, `WAIT`, `DATA`, `ERR1`, `ERR2`);
  - a byte-strobe function `f(hsize, addr[1:0])` returning 4 bits.
- **Sub-module `ahb_slv_mem_array`:** `MEM_DEPTH`×32 array with 4-bit byte-enable write and asynchronous read.

## Test plan
- **Reset and basic write/read** (`WAIT_STATES`=0): hold reset, release, write word `0xDEADBEEF` to `0x10`, then read `0x10`.
  - After reset: `HREADYout`=1, `HRESP`=00, `HRDATA`=0.
  - Read returns `0xDEADBEEF` on the cycle after its address phase.
- **Byte-lane writes:** word `0x00000000` at `0x20`; byte write `0xAA` to `0x21`; halfword write `0x1234` to `0x22`; read `0x20`.
  - Read returns `0x1234AA00`.
- **Wait states** (`WAIT_STATES`=3): back-to-back INCR4 write to `0x40`.
  - Each beat: `HREADYout` low for 3 cycles, then high.
  - Read-back returns all 4 words.
- **Pipelined write-then-read:** write `0x5A5A5A5A` to `0x8` immediately followed by a read of `0x8`.
  - Read returns `0x5A5A5A5A`.
- **Error responses** (`AHB_SLV_ERR_EN` defined, `MEM_DEPTH`=256): read `0x400`, then word write to `0x2`.
  - Each transfer gets `HRESP`=01 for 2 cycles with `HREADYout` 0 then 1.
  - The memory at `0x0` is unchanged.
- **IDLE/BUSY and reset mid-transfer:**
  - IDLE and BUSY beats get zero-wait OKAY.
  - Reset asserted during a `WAIT` cycle of a write returns all outputs to reset values, and the write is not committed.

Source files
------------

// File: rtl/ahb_slv_pkg.sv
// Shared encodings, FSM states and byte-strobe helper for the AHB-Lite SRAM slave.
// AHB_SLV_ERR_EN adds the two ERROR-response states.
package ahb_slv_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
`ifdef AHB_SLV_ERR_EN
    , S_ERR1,
    S_ERR2
`endif
  } slv_state_e;

  // Little-endian lane enables; sizes above word fall through to a full word.
  function automatic logic [3:0] byte_strobe(input logic [2:0] hsize, input logic [1:0] addr_lo);
    case (hsize)
      HSIZE_BYTE: return 4'b0001 << addr_lo;
      HSIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite signal bundle between a master agent and the SRAM slave.
interface ahb_slave_mem_if;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYin;
  logic        HREADYout;
  logic [1:0]  HRESP;

  modport master (
    output HTRANS, HBURST, HSIZE, HADDR, HWRITE, HWDATA, HREADYin,
    input  HRDATA, HREADYout, HRESP
  );

  modport slave (
    input  HTRANS, HBURST, HSIZE, HADDR, HWRITE, HWDATA, HREADYin,
    output HRDATA, HREADYout, HRESP
  );
endinterface

// File: rtl/ahb_slv_mem_array.sv
// MEM_DEPTH x 32 storage with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module ahb_slv_mem_array #(
  parameter int unsigned MEM_DEPTH = 256,
  localparam int unsigned AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (wr_be[i]) mem[addr][i*8 +: 8] <= wr_data[i*8 +: 8];
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word-organised SRAM slave with configurable wait states.
// Define AHB_SLV_ERR_EN to enable legality checks and the two-cycle ERROR response.
module ahb_slave_mem
  import ahb_slv_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic           HCLK,
  input logic           HRESET_n,
  ahb_slave_mem_if.slave bus
);

  localparam int unsigned AW        = $clog2(MEM_DEPTH);
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slv_state_e  state;
  logic [3:0]  wait_cnt;
  logic        ready_q;
  hresp_e      resp_q;
  logic [AW+1:0] addr_q;
  logic [2:0]  size_q;
  logic        write_q;

  logic        active;
  logic        accept;
  logic [3:0]  wr_be;
  logic [31:0] rd_word;

  assign active = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
  // ready_q is high exactly in IDLE/DATA/ERR2, the states that may take a new address phase.
  assign accept = bus.HREADYin && ready_q && active;

`ifdef AHB_SLV_ERR_EN
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);
  logic illegal;
  logic unused_bits;

  assign illegal = (bus.HADDR >= MEM_BYTES)
                || (bus.HSIZE > HSIZE_WORD)
                || ((bus.HSIZE == HSIZE_HALF) && bus.HADDR[0])
                || ((bus.HSIZE == HSIZE_WORD) && (bus.HADDR[1:0] != 2'b00));
  assign unused_bits = ^bus.HBURST;
`else
  // Upper address bits drop out: accesses wrap modulo the array size.
  logic unused_bits;
  assign unused_bits = ^{bus.HBURST, bus.HADDR[31:AW+2]};
`endif

  always_ff @(posedge HCLK or negedge HRESET_n) begin
    if (!HRESET_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      ready_q  <= 1'b1;
      resp_q   <= HRESP_OKAY;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == '0) begin
            state   <= S_DATA;
            ready_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
`ifdef AHB_SLV_ERR_EN
        S_ERR1: begin
          state   <= S_ERR2;
          ready_q <= 1'b1;
          resp_q  <= HRESP_ERROR;
        end
`endif
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
          resp_q  <= HRESP_OKAY;
          if (accept) begin
            addr_q  <= bus.HADDR[AW+1:0];
            size_q  <= bus.HSIZE;
            write_q <= bus.HWRITE;
`ifdef AHB_SLV_ERR_EN
            if (illegal) begin
              state   <= S_ERR1;
              ready_q <= 1'b0;
              resp_q  <= HRESP_ERROR;
            end else
`endif
            if (WAIT_STATES > 0) begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
              ready_q  <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
      endcase
    end
  end

  assign wr_be = ((state == S_DATA) && write_q) ? byte_strobe(size_q, addr_q[1:0]) : 4'b0000;

  ahb_slv_mem_array #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_array (
    .clk     (HCLK),
    .wr_be   (wr_be),
    .addr    (addr_q[AW+1:2]),
    .wr_data (bus.HWDATA),
    .rd_data (rd_word)
  );

  assign bus.HRDATA    = ((state == S_DATA) && !write_q) ? rd_word : '0;
  assign bus.HREADYout = ready_q;
  assign bus.HRESP     = resp_q;

endmodule
